// File: rtl/loop_seq_ctrl_pkg.sv
// Shared types and constants for the i/x/y loop sequencing controller.
// State encoding and strobe-bundle bit positions live here.
package loop_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ACCUM = 3'd2,
        TEST  = 3'd3,
        CLR_Y = 3'd4,
        CLR_X = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam int unsigned STB_W = 6;

    typedef logic [STB_W-1:0] stb_t;

    localparam int unsigned I_LOAD  = 0;
    localparam int unsigned I_CLEAR = 1;
    localparam int unsigned X_LOAD  = 2;
    localparam int unsigned X_CLEAR = 3;
    localparam int unsigned Y_LOAD  = 4;
    localparam int unsigned Y_CLEAR = 5;

    localparam stb_t STB_OFF = 6'b111111;

endpackage

// File: rtl/loop_seq_ctrl_if.sv
// Control/status bundle between the system control path, the
// sequencer and the i/x/y datapath.
interface loop_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             i_lte_limit;
    logic             x_lt_zero;
    logic             i_load;
    logic             i_clear;
    logic             x_load;
    logic             x_clear;
    logic             y_load;
    logic             y_clear;
    logic             busy;
    logic             done;
    logic             err;
    logic             took_y_branch;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, abort, i_lte_limit, x_lt_zero,
        input  i_load, i_clear, x_load, x_clear,
        input  y_load, y_clear, busy, done, err,
        input  took_y_branch, iter_count
    );

    modport slave (
        input  start, abort, i_lte_limit, x_lt_zero,
        output i_load, i_clear, x_load, x_clear,
        output y_load, y_clear, busy, done, err,
        output took_y_branch, iter_count
    );
endinterface

// File: rtl/loop_seq_ctrl_iter_counter.sv
// Iteration counter with synchronous clear/enable and a terminal
// compare used as the run watchdog.
module loop_seq_ctrl_iter_counter #(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == CNT_W'(MAX_ITER));
endmodule

// File: rtl/loop_seq_ctrl.sv
// Sequencer for the loop: x=0,i=0; while i<=limit {i++, x+=y};
// then y=0 if x<0 else x=0. Start/done handshake, abort, watchdog.
module loop_seq_ctrl
    import loop_seq_ctrl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input logic            clock,
    input logic            reset,
    loop_seq_ctrl_if.slave bus
);
    state_e state_q, state_d;
    stb_t   stb;
    logic   err_q, err_d;
    logic   tyb_q, tyb_d;
    logic   cnt_clr, cnt_en, at_max, done_c;

    loop_seq_ctrl_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter (
        .clk      (clock),
        .rst_n    (reset),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .count_o  (bus.iter_count),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d = state_q;
        stb     = STB_OFF;
        err_d   = err_q;
        tyb_d   = tyb_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start)
                    state_d = INIT;
            end
            INIT: begin
                stb[I_CLEAR] = 1'b0;
                stb[X_CLEAR] = 1'b0;
                stb[Y_LOAD]  = 1'b0;
                err_d   = 1'b0;
                tyb_d   = 1'b0;
                cnt_clr = 1'b1;
                state_d = ACCUM;
            end
            ACCUM: begin
                stb[I_LOAD] = 1'b0;
                stb[X_LOAD] = 1'b0;
                cnt_en  = 1'b1;
                state_d = TEST;
            end
            TEST: begin
                if (bus.i_lte_limit) begin
                    if (at_max) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if (bus.x_lt_zero) begin
                    state_d = CLR_Y;
                end else begin
                    state_d = CLR_X;
                end
            end
            CLR_Y: begin
                stb[Y_CLEAR] = 1'b0;
                tyb_d   = 1'b1;
                state_d = DONE;
            end
            CLR_X: begin
                stb[X_CLEAR] = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort still lets the counter record an aborted ACCUM cycle
        if (bus.abort && state_q != IDLE) begin
            stb     = STB_OFF;
            err_d   = err_q;
            tyb_d   = tyb_q;
            cnt_clr = 1'b0;
            done_c  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            tyb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tyb_q   <= tyb_d;
        end
    end

    assign bus.i_load        = stb[I_LOAD];
    assign bus.i_clear       = stb[I_CLEAR];
    assign bus.x_load        = stb[X_LOAD];
    assign bus.x_clear       = stb[X_CLEAR];
    assign bus.y_load        = stb[Y_LOAD];
    assign bus.y_clear       = stb[Y_CLEAR];
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_c;
    assign bus.err           = err_q;
    assign bus.took_y_branch = tyb_q;
endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Bench for loop_seq_ctrl: datapath model plus directed and random
// runs checked against expectations derived from the loop semantics.
module tb_loop_seq_ctrl;
    localparam int CNT_W    = 8;
    localparam int MAX_ITER = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    loop_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    loop_seq_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int limit     = 0;
    int y_operand = 0;
    int m_i = 0, m_x = 0, m_y = 0;

    always @(posedge clock) begin
        if (!bus.i_clear) m_i <= 0;
        else if (!bus.i_load) m_i <= m_i + 1;
        if (!bus.x_clear) m_x <= 0;
        else if (!bus.x_load) m_x <= m_x + m_y;
        if (!bus.y_clear) m_y <= 0;
        else if (!bus.y_load) m_y <= y_operand;
    end

    assign bus.i_lte_limit = (m_i <= limit);
    assign bus.x_lt_zero   = (m_x < 0);

    wire [5:0] stbs = {bus.y_clear, bus.y_load, bus.x_clear,
                       bus.x_load, bus.i_clear, bus.i_load};
    wire conflict = (!bus.i_load && !bus.i_clear) ||
                    (!bus.x_load && !bus.x_clear) ||
                    (!bus.y_load && !bus.y_clear);

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int lim, input int yv);
        int n, exp_done, exp_cx, exp_cy, exp_x, exp_y;
        int done_cyc, cx, cy, accums, confl;
        bit wd, xneg;
        limit = lim;
        y_operand = yv;
        wd = (lim >= MAX_ITER);
        n  = wd ? MAX_ITER : lim + 1;
        xneg = (n * yv) < 0;
        exp_done = wd ? 2 * n + 2 : 2 * n + 3;
        exp_cx = (!wd && !xneg) ? 2 * n + 2 : -1;
        exp_cy = (!wd && xneg) ? 2 * n + 2 : -1;
        exp_x  = (!wd && !xneg) ? 0 : n * yv;
        exp_y  = (!wd && xneg) ? 0 : yv;
        @(negedge clock);
        bus.start = 1'b1;
        #1 chk("idle_busy", int'(bus.busy), 0);
        done_cyc = -1; cx = -1; cy = -1; accums = 0; confl = 0;
        for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            #1;
            if (!bus.i_load) accums++;
            if (!bus.x_clear && k != 1) cx = k;
            if (!bus.y_clear) cy = k;
            if (conflict) confl++;
            if (bus.done) done_cyc = k;
        end
        chk("done_cycle", done_cyc, exp_done);
        chk("accum_cycles", accums, n);
        chk("iter_count", int'(bus.iter_count), n);
        chk("err", int'(bus.err), int'(wd));
        chk("took_y", int'(bus.took_y_branch), int'(!wd && xneg));
        chk("clr_x_cycle", cx, exp_cx);
        chk("clr_y_cycle", cy, exp_cy);
        chk("final_x", m_x, exp_x);
        chk("final_y", m_y, exp_y);
        chk("strobe_conflict", confl, 0);
        @(negedge clock);
        #1 chk("post_done_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_strobes", int'(stbs), 6'h3f);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_tyb", int'(bus.took_y_branch), 0);
        chk("rst_iter", int'(bus.iter_count), 0);
        reset = 1'b1;

        run(10, 3);
        run(10, -2);
        run(30, 5);

        limit = 10; y_operand = 1;
        @(negedge clock);
        bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (k == 6) begin
                #1 chk("abort_pre_iload", int'(bus.i_load), 0);
                bus.abort = 1'b1;
                #1 chk("abort_strobes", int'(stbs), 6'h3f);
            end
            if (k == 7) begin
                bus.abort = 1'b0;
                #1;
                chk("abort_busy", int'(bus.busy), 0);
                chk("abort_done", int'(bus.done), 0);
                chk("abort_iter", int'(bus.iter_count), 3);
            end
        end
        dones = 0;
        repeat (4) begin
            @(negedge clock);
            #1 if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_iter_frozen", int'(bus.iter_count), 3);

        @(negedge clock);
        bus.start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (k == 10) reset = 1'b0;
            if (k == 11) begin
                #1;
                chk("mrst_strobes", int'(stbs), 6'h3f);
                chk("mrst_busy", int'(bus.busy), 0);
                chk("mrst_done", int'(bus.done), 0);
                chk("mrst_err", int'(bus.err), 0);
                chk("mrst_tyb", int'(bus.took_y_branch), 0);
                chk("mrst_iter", int'(bus.iter_count), 0);
                reset = 1'b1;
            end
        end

        limit = 10; y_operand = 2;
        @(negedge clock);
        bus.start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clock);
            if (k == 52) bus.start = 1'b0;
            #1;
            if (bus.done) dones++;
            if (k == 25) chk("held_done1", int'(bus.done), 1);
            if (k == 26) chk("held_idle_gap", int'(bus.busy), 0);
            if (k == 27) begin
                chk("held_init_busy", int'(bus.busy), 1);
                chk("held_init_iclr", int'(bus.i_clear), 0);
            end
            if (k == 51) chk("held_done2", int'(bus.done), 1);
            if (k == 53) chk("held_stop_busy", int'(bus.busy), 0);
        end
        chk("held_done_count", dones, 2);

        for (int r = 0; r < 8; r++)
            run(int'($urandom_range(0, 24)),
                int'($urandom_range(0, 20)) - 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loop_seq_ctrl.md
Name: loop_seq_ctrl

Overview:
Sequencing controller for the i/x/y accumulate datapath: registers i, x, y with active-low load/clear strobes, two adders, and the i<=limit and x<0 comparators. It runs the loop "x=0, i=0; while i<=limit: i=i+1, x=x+y; then if x<0 y=0 else x=0" under a start/done handshake. It also supports abort and has an iteration watchdog. It sits between the system control path and the datapath and replaces ad-hoc hardwired strobe sequencing.

Parameters:
CNT_W, 8, width of the internal iteration counter and the iter_count output
MAX_ITER, 255, watchdog limit on ACCUM cycles per run (1..2^CNT_W-1)

Ports:
clock  input  1  single system clock; all state changes on its rising edge
reset  input  1  synchronous, active-low; sampled on rising clock edge
start  input  1  request a run; sampled only in IDLE
abort  input  1  terminate the current run; ignored in IDLE
i_lte_limit  input  1  datapath status: registered i <= limit
x_lt_zero  input  1  datapath status: registered x < 0
i_load  output  1  active-low load strobe, register i
i_clear  output  1  active-low clear strobe, register i
x_load  output  1  active-low load strobe, register x
x_clear  output  1  active-low clear strobe, register x
y_load  output  1  active-low load strobe, register y (captures operand)
y_clear  output  1  active-low clear strobe, register y
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at run completion (normal or watchdog)
err  output  1  watchdog fired on the last run; held until the next INIT
took_y_branch  output  1  last run cleared y (x<0); held until the next INIT
iter_count  output  CNT_W  ACCUM cycles in the current or last run

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; all six strobes=1; busy, done, err, took_y_branch=0; iter_count=0. Reset has priority over every other input in every state.
- Strobes are Moore outputs decoded from state; the abort override below is the only exception. A strobe not listed for a state is 1. Clear and load on the same register are never both 0.
- IDLE: busy=0. start=1 -> INIT.
- INIT: i_clear=0, x_clear=0, y_load=0. Clears err, took_y_branch and iter_count. -> ACCUM.
- ACCUM: i_load=0, x_load=0 (i<=i+1, x<=x+y). iter_count increments. -> TEST.
- TEST: no strobes; this cycle lets the comparators settle on the updated registers.
  - i_lte_limit=1 and iter_count==MAX_ITER -> DONE, err<=1.
  - i_lte_limit=1 otherwise -> ACCUM.
  - i_lte_limit=0 and x_lt_zero=1 -> CLR_Y.
  - i_lte_limit=0 and x_lt_zero=0 -> CLR_X.
- CLR_Y: y_clear=0, took_y_branch<=1 -> DONE.
- CLR_X: x_clear=0 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. A start in this cycle is ignored.
- Abort: abort=1 in any state other than IDLE forces all strobes to 1 in that same cycle (combinational override) and sends the next state to IDLE. No done pulse is issued; err and took_y_branch keep their values; iter_count freezes.
- Priority: reset > abort > watchdog > normal transitions.
- start while busy=1 is ignored; no queuing.
- Latency with limit=10 (11 accumulations): start sampled in cycle 0 (IDLE); INIT in cycle 1; ACCUM/TEST pairs in cycles 2..23; CLR in cycle 24; done=1 in cycle 25; IDLE in cycle 26. In general, done is high in cycle 2N+3 for N accumulations.
- iter_count does not wrap; MAX_ITER < 2^CNT_W guarantees the watchdog fires before overflow.
- State encoding: 3 bits, 7 states used. An unused encoding returns to IDLE on the next edge with all strobes inactive.

Decomposition:
- Shared package (ctrl_pkg): state localparams IDLE, INIT, ACCUM, TEST, CLR_Y, CLR_X, DONE; the inactive strobe-bundle constant 6'b111111; strobe bit-index constants.
- One sub-module, iter_counter: CNT_W-wide counter with synchronous clear and enable and a terminal-compare output (count==MAX_ITER). It is instantiated once for iter_count and the watchdog.

Test Plan:
- Normal run, x>=0: limit=10, y=3, i_lte_limit driven from a datapath model -> 11 ACCUM cycles, x_clear=0 in cycle 24, done=1 in cycle 25, iter_count=11, took_y_branch=0, err=0.
- Negative branch: same run with x_lt_zero=1 at exit -> y_clear=0 in cycle 24, done in cycle 25, took_y_branch=1.
- Watchdog: MAX_ITER=16, i_lte_limit held at 1 -> done in cycle 2*16+2=34, err=1, no CLR strobe issued, iter_count=16.
- Abort: abort=1 during the 3rd ACCUM cycle (cycle 6) -> all strobes 1 in cycle 6, IDLE in cycle 7, no done pulse, busy=0, iter_count=3.
- Reset mid-run: reset=0 in cycle 10 -> in cycle 11 state is IDLE, all strobes 1, busy, done, err, took_y_branch=0, iter_count=0.
- Start ignored: start=1 held through an entire run -> runs back to back, each separated by exactly one IDLE cycle (IDLE in cycle 26, INIT in cycle 27). No second run is started from the DONE cycle.
